ps2_mouse_receiver: RTL
=======================

Name: ps2_mouse_receiver

Overview:
PS/2 device-to-host byte receiver that sits directly upstream of the mouse master state machine. It samples the mouse clock and data lines, deserialises one 11-bit PS/2 frame, and checks parity and the stop bit. It presents each byte with an error code and a one-cycle ready pulse. The master state machine gates reception through READ_ENABLE.

Parameters:
TIMEOUT_CYCLES, 250_000, CLK cycles allowed between PS/2 clock falling edges inside a frame before abort (5 ms at 50 MHz); set to 2_500 under SIMULATION
SYNC_STAGES, 2, flip-flop depth of the input synchronisers (min 2)

Ports:
CLK  input  1  system clock, 50 MHz
RESET  input  1  asynchronous, active-low reset
CLK_MOUSE_IN  input  1  raw PS/2 clock line from the mouse, asynchronous
DATA_MOUSE_IN  input  1  raw PS/2 data line from the mouse, asynchronous
READ_ENABLE  input  1  from master SM; 1 = reception allowed
BYTE_READ  output  8  last received data byte
BYTE_ERROR_CODE  output  2  bit0 = parity error, bit1 = stop-bit error; 00 = good
BYTE_READY  output  1  one-cycle pulse; byte and error code are valid
rx_state  output  3  debug: current FSM state encoding

Behaviour:
- Reset values: BYTE_READ=8'h00, BYTE_ERROR_CODE=2'b00, BYTE_READY=0, FSM=IDLE, shift register=0, bit counter=0, timeout counter=0, synchronisers=1 (lines idle high).
- Inputs pass through SYNC_STAGES flip-flops, then one edge register. A falling edge ("fe") is synchronised previous=1 and current=0. The data bit is sampled from the synchronised data line in the fe cycle.
- FSM states:
  - IDLE: on fe with READ_ENABLE=1 and data=0 (start bit), go to RX_DATA and clear the bit counter. A start bit of 1 is a glitch: stay in IDLE. Edges with READ_ENABLE=0 are ignored.
  - RX_DATA: on each fe, shift the bit in LSB-first and increment the counter. After the 8th bit, go to RX_PARITY.
  - RX_PARITY: on fe, store the parity bit and go to RX_STOP.
  - RX_STOP: on fe, store the stop bit and go to EMIT.
  - EMIT: exactly one cycle. BYTE_READY=1. BYTE_READ and BYTE_ERROR_CODE are registered in the same cycle. Then return to IDLE.
- Error code:
  - bit0 = ~(^{data[7:0], parity}), i.e. odd parity is required.
  - bit1 = ~stop.
  - Both bits can be set (2'b11).
  - The byte is delivered even when an error is flagged.
- BYTE_READ and BYTE_ERROR_CODE hold their values until the next EMIT.
- Latency: BYTE_READY rises one CLK after the fe cycle of the stop bit.
- Timeout:
  - The counter runs in RX_DATA, RX_PARITY and RX_STOP, and clears on every fe and in IDLE/EMIT.
  - When it reaches TIMEOUT_CYCLES-1 without a fe, the FSM returns to IDLE with no BYTE_READY pulse and outputs unchanged.
- READ_ENABLE deasserted in any non-IDLE state except EMIT: abort to IDLE the next cycle with no pulse. EMIT always completes.
- If a fe and a timeout expiry occur in the same cycle, the fe wins.
- RESET asserted mid-frame: immediate return to reset values. The partial frame is discarded.
- Counter width is $clog2(TIMEOUT_CYCLES), with wrap-around impossible by construction.

Decomposition:
- Package ps2_pkg holds:
  - rx state enum (IDLE, RX_DATA, RX_PARITY, RX_STOP, EMIT)
  - error-code constants (ERR_NONE=2'b00, ERR_PARITY=2'b01, ERR_STOP=2'b10)
  - PS2_DATA_BITS=8
  - the TIMEOUT default under SIMULATION
- Sub-module ps2_sync_edge: SYNC_STAGES synchroniser for the clock and data lines plus the falling-edge detector. Outputs are the fe pulse and the synchronised data.

Test Plan:
- 0xFA frame (start 0, data LSB-first, parity 1, stop 1), PS/2 period 80 us, READ_ENABLE=1 -> one BYTE_READY pulse; BYTE_READ=8'hFA, code=2'b00; pulse one CLK after the stop fe.
- Back-to-back 0xAA (parity 1) then 0xF4 (parity 0) -> two pulses; BYTE_READ=8'hAA then 8'hF4, both code 2'b00; outputs held between pulses.
- 0x08 sent with parity 1 -> BYTE_READ=8'h08, code=2'b01. 0x08 with correct parity 0 but stop 0 -> code=2'b10. Parity 1 and stop 0 -> code=2'b11.
- Frame stalls after 5 data bits for TIMEOUT_CYCLES+10 cycles -> no pulse, FSM=IDLE, BYTE_READ unchanged. A following valid 0xF4 frame -> BYTE_READ=8'hF4, code=2'b00.
- READ_ENABLE=0 during an entire 0xFA frame -> no pulse. READ_ENABLE dropped after bit 3 -> IDLE next cycle, no pulse.
- RESET pulsed low after bit 4 of 0xFA -> all outputs at reset values. A subsequent full 0xAA frame -> BYTE_READ=8'hAA, code=2'b00.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse byte receiver.
package ps2_pkg;

    // Receiver FSM states; the encoding is exported on the rx_state debug port.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_DATA   = 3'd1,
        RX_PARITY = 3'd2,
        RX_STOP   = 3'd3,
        EMIT      = 3'd4
    } rx_state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_PARITY = 2'b01;
    localparam logic [1:0] ERR_STOP   = 2'b10;

    localparam int PS2_DATA_BITS = 8;

    // Inter-edge timeout: 5 ms at 50 MHz on silicon, shortened in simulation.
`ifdef SIMULATION
    localparam int TIMEOUT_DEFAULT = 2_500;
`else
    localparam int TIMEOUT_DEFAULT = 250_000;
`endif

    // PS/2 uses odd parity over data+parity; a low stop bit is a framing error.
    function automatic logic [1:0] frame_error(input logic [PS2_DATA_BITS-1:0] data,
                                               input logic parity,
                                               input logic stop);
        logic [1:0] err;
        err = ERR_NONE;
        if (~(^{data, parity})) err = err | ERR_PARITY;
        if (~stop)              err = err | ERR_STOP;
        return err;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises the raw PS/2 clock and data lines and flags PS/2 clock
// falling edges. Both lines share the same synchroniser depth so the data
// bit presented in the edge cycle is the one that was stable at the edge.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clk_raw,
    input  logic data_raw,
    output logic fe,
    output logic data_sync
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_d;
    logic                   clk_prev_q;
    logic                   clk_prev_d;

    // Shift raw lines into the synchroniser chains; remember the last synced clock.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], clk_raw};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], data_raw};
        clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    end

    // Lines idle high, so every stage resets to 1 and no edge fires out of reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    assign fe        = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign data_sync = data_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_mouse_receiver.sv
// PS/2 device-to-host byte receiver. Deserialises one 11-bit frame
// (start, 8 data LSB-first, odd parity, stop), then pulses BYTE_READY for
// one cycle with the byte and its error code. Reception is gated by
// READ_ENABLE; a stalled frame is dropped after TIMEOUT_CYCLES.
module ps2_mouse_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY,
    output logic [2:0] rx_state
);

    localparam int CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BIT_CNT_W = $clog2(PS2_DATA_BITS);

    localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT     = BIT_CNT_W'(PS2_DATA_BITS - 1);

    logic fe;
    logic data_s;

    rx_state_t                state_q,   state_d;
    logic [PS2_DATA_BITS-1:0] shift_q,   shift_d;
    logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                     parity_q,  parity_d;
    logic [CNT_W-1:0]         tmo_q,     tmo_d;
    logic [7:0]               byte_q,    byte_d;
    logic [1:0]               err_q,     err_d;
    logic                     ready_q,   ready_d;

    logic in_frame;
    logic tmo_expired;

    ps2_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .CLK       (CLK),
        .RESET     (RESET),
        .clk_raw   (CLK_MOUSE_IN),
        .data_raw  (DATA_MOUSE_IN),
        .fe        (fe),
        .data_sync (data_s)
    );

    assign in_frame    = (state_q == RX_DATA) || (state_q == RX_PARITY) || (state_q == RX_STOP);
    assign tmo_expired = (tmo_q == TIMEOUT_LAST);

    // Next-state and next-output logic. Priority inside a frame:
    // READ_ENABLE abort, then a PS/2 edge, then timeout expiry.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        tmo_d     = '0;
        byte_d    = byte_q;
        err_d     = err_q;
        ready_d   = 1'b0;

        if (in_frame) begin
            if (!READ_ENABLE) begin
                state_d = IDLE;
            end else if (fe) begin
                unique case (state_q)
                    RX_DATA: begin
                        shift_d   = {data_s, shift_q[PS2_DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) state_d = RX_PARITY;
                    end
                    RX_PARITY: begin
                        parity_d = data_s;
                        state_d  = RX_STOP;
                    end
                    default: begin
                        // RX_STOP: outputs are loaded so they are valid during EMIT.
                        state_d = EMIT;
                        byte_d  = shift_q;
                        err_d   = frame_error(shift_q, parity_q, data_s);
                        ready_d = 1'b1;
                    end
                endcase
            end else if (tmo_expired) begin
                state_d = IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else if (state_q == IDLE) begin
            if (fe && READ_ENABLE && !data_s) begin
                state_d   = RX_DATA;
                bit_cnt_d = '0;
            end
        end else begin
            // EMIT lasts exactly one cycle regardless of READ_ENABLE.
            state_d = IDLE;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tmo_q     <= '0;
            byte_q    <= 8'h00;
            err_q     <= ERR_NONE;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tmo_q     <= tmo_d;
            byte_q    <= byte_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
        end
    end

    assign BYTE_READ       = byte_q;
    assign BYTE_ERROR_CODE = err_q;
    assign BYTE_READY      = ready_q;
    assign rx_state        = state_q;

endmodule
